serial_frame_rx: RTL and testbench

//   Downstream consumer of the 4-bit serial-in shift register. Samples its parallel window q3..q0

---
 rtl/serial_frame_rx.sv | 161 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Watches the 4-bit parallel window of an upstream serial-in shift register
// (one new bit per clock), hunts for a sync nibble at any bit alignment, then
// assembles the following NIBBLES nibbles into a word. The word is offered on
// a valid/ready port. A completed frame that cannot be handed over because the
// previous one is still pending is dropped and flagged in a sticky overrun bit.

module serial_frame_rx #(
  parameter logic [3:0] SYNC    = 4'hA,  // wire order, first-received bit is MSB
  parameter int         NIBBLES = 2,     // payload nibbles per frame, 1..8
  localparam int        W       = 4 * NIBBLES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         q3,          // newest bit
  input  logic         q2,
  input  logic         q1,
  input  logic         q0,          // oldest bit
  output logic [W-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Index of the final payload nibble; the capture of this nibble completes a frame.
  localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);

  // Blank count loaded on reset: the reset-time window holds no fresh bits,
  // so four new bits must arrive before the first compare.
  localparam logic [2:0] BLANK_RESET = 3'd4;

  // Blank count loaded on completion: the bit entering at the completion edge
  // is already fresh, so only three more are needed for a clean window.
  localparam logic [2:0] BLANK_DONE = 3'd3;

  state_t         state_q,      state_d;
  logic [1:0]     phase_q,      phase_d;
  logic [2:0]     nib_cnt_q,    nib_cnt_d;
  logic [2:0]     blank_q,      blank_d;
  logic [W-1:0]   asm_q,        asm_d;
  logic [W-1:0]   data_out_q,   data_out_d;
  logic           data_valid_q, data_valid_d;
  logic           busy_q,       busy_d;
  logic           overrun_q,    overrun_d;

  logic [3:0]     sample;
  logic           detect;
  logic           capture;
  logic           complete;
  logic [W-1:0]   asm_shift;

  // Oldest bit lands in the MSB so the sample reads in wire order.
  assign sample = {q0, q1, q2, q3};

  // Only a window made entirely of uncompared bits may match the sync nibble.
  assign detect = (state_q == HUNT) && (blank_q == 3'd0) && (sample == SYNC);

  // Every fourth edge after detect a fully fresh nibble sits in the window.
  assign capture  = (state_q == COLLECT) && (phase_q == 2'd3);
  assign complete = capture && (nib_cnt_q == LAST_NIB);

  // Assembly register with the current sample appended; nibble0 ends up in the MS bits.
  assign asm_shift = (asm_q << 4) | W'(sample);

  // State and datapath registers; reset acts immediately and drops any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      phase_q      <= 2'd0;
      nib_cnt_q    <= 3'd0;
      blank_q      <= BLANK_RESET;
      asm_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      nib_cnt_q    <= nib_cnt_d;
      blank_q      <= blank_d;
      asm_q        <= asm_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: sync hunt with blanking, then nibble collection.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    nib_cnt_d = nib_cnt_q;
    blank_d   = blank_q;
    asm_d     = asm_q;

    case (state_q)
      HUNT: begin
        if (blank_q != 3'd0) begin
          blank_d = blank_q - 3'd1;
        end else if (detect) begin
          state_d   = COLLECT;
          phase_d   = 2'd0;
          nib_cnt_d = 3'd0;
          asm_d     = '0;
        end
      end

      COLLECT: begin
        // Payload nibbles equal to SYNC are ordinary data; no compare happens here.
        phase_d = phase_q + 2'd1;
        if (capture) begin
          asm_d     = asm_shift;
          nib_cnt_d = nib_cnt_q + 3'd1;
        end
        if (complete) begin
          state_d   = HUNT;
          nib_cnt_d = 3'd0;
          blank_d   = BLANK_DONE;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // Output logic: frame hand-off, consumer handshake, overrun flag and busy.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d == COLLECT);

    if (complete) begin
      // A pending word being taken on this same edge frees the slot for the new one.
      if (!data_valid_q || data_ready) begin
        data_out_d   = asm_shift;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Directed bench: drives an emulated 4-bit serial-in shift register into the
// receiver and checks frame assembly, blanking, handshake, overrun and reset.

module tb_serial_frame_rx;

  logic       clock = 1'b0;
  logic       reset;
  logic       q3, q2, q1, q0;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  // Second receiver with an all-zero sync nibble, for the reset blanking check.
  logic [7:0] data_out0;
  logic       data_valid0;
  logic       busy0;
  logic       overrun0;

  int checks   = 0;
  int failures = 0;

  serial_frame_rx #(.SYNC(4'hA), .NIBBLES(2)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .q3         (q3),
    .q2         (q2),
    .q1         (q1),
    .q0         (q0),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  serial_frame_rx #(.SYNC(4'h0), .NIBBLES(2)) u_dut0 (
    .clock      (clock),
    .reset      (reset),
    .q3         (q3),
    .q2         (q2),
    .q1         (q1),
    .q0         (q0),
    .data_out   (data_out0),
    .data_valid (data_valid0),
    .data_ready (data_ready),
    .busy       (busy0),
    .overrun    (overrun0)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One edge of the upstream shift register: new bit enters q3, the rest move down.
  task automatic push_bit(input logic b);
    @(posedge clock);
    #1;
    q0 = q1;
    q1 = q2;
    q2 = q3;
    q3 = b;
  endtask

  task automatic push_nib(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) push_bit(n[i]);
  endtask

  // Reset released at a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    {q3, q2, q1, q0} = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Frame 35 then back-to-back frame 7E; stops after edge 24 (frame 2 completes at 25).
  task automatic two_frames_upto_24();
    push_nib(4'hA);                  // edges 1..4, detect at 5
    push_nib(4'h3);                  // edges 5..8
    push_nib(4'h5);                  // edges 9..12
    push_bit(1'b1);                  // edge 13: frame 1 completes, sync bit 1 enters
    check_val("t4_f1_data", 32'(data_out), 32'h35);
    check_val("t4_f1_valid", 32'(data_valid), 32'h1);
    check_val("t4_f1_ovr", 32'(overrun), 32'h0);
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b0);                  // edge 16
    push_bit(1'b0);                  // edge 17: detect of frame 2
    check_val("t4_f2_busy", 32'(busy), 32'h1);
    push_bit(1'b1);
    push_bit(1'b1);
    push_bit(1'b1);                  // edge 20
    push_nib(4'hE);                  // edges 21..24
  endtask

  initial begin
    reset      = 1'b1;
    data_ready = 1'b1;
    {q3, q2, q1, q0} = 4'b0000;

    #12;
    check_val("rst_data", 32'(data_out), 32'h0);
    check_val("rst_valid", 32'(data_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_ovr", 32'(overrun), 32'h0);

    // 1: basic frame A | 3 5 with ready high
    do_reset();
    data_ready = 1'b1;
    push_nib(4'hA);
    check_val("t1_busy_pre", 32'(busy), 32'h0);
    push_bit(1'b0);                  // edge 5 = D
    check_val("t1_busy_D", 32'(busy), 32'h1);
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b1);
    push_nib(4'h5);                  // edge 12 = D+7
    check_val("t1_busy_D7", 32'(busy), 32'h1);
    check_val("t1_valid_D7", 32'(data_valid), 32'h0);
    push_bit(1'b0);                  // edge 13 = D+8
    check_val("t1_data", 32'(data_out), 32'h35);
    check_val("t1_valid", 32'(data_valid), 32'h1);
    check_val("t1_busy_done", 32'(busy), 32'h0);
    push_bit(1'b0);
    check_val("t1_valid_taken", 32'(data_valid), 32'h0);
    $display("scenario 1: frame %0h received", 8'h35);

    // 2: blanking after reset, seen on the SYNC=0 receiver
    do_reset();
    repeat (4) push_bit(1'b0);
    check_val("t2_busy_e4", 32'(busy0), 32'h0);
    push_bit(1'b0);                  // edge 5: first compare
    check_val("t2_busy_e5", 32'(busy0), 32'h1);
    repeat (8) push_bit(1'b0);       // edges 6..13
    check_val("t2_valid", 32'(data_valid0), 32'h1);
    check_val("t2_data", 32'(data_out0), 32'h00);
    check_val("t2_ovr", 32'(overrun0), 32'h0);
    check_val("t2_main_idle", 32'(busy), 32'h0);
    $display("scenario 2: zero-sync detect at edge 5");

    // 3: payload contains the sync value
    do_reset();
    push_nib(4'hA);
    push_nib(4'hA);
    push_nib(4'h5);
    check_val("t3_busy_D7", 32'(busy), 32'h1);
    push_bit(1'b0);
    check_val("t3_data", 32'(data_out), 32'hA5);
    check_val("t3_valid", 32'(data_valid), 32'h1);
    check_val("t3_busy_done", 32'(busy), 32'h0);
    $display("scenario 3: frame %0h received", 8'hA5);

    // 4: back-pressure drops the second frame
    do_reset();
    data_ready = 1'b0;
    two_frames_upto_24();
    push_bit(1'b0);                  // edge 25: frame 2 completes
    check_val("t4_ovr", 32'(overrun), 32'h1);
    check_val("t4_data_held", 32'(data_out), 32'h35);
    check_val("t4_valid", 32'(data_valid), 32'h1);
    check_val("t4_busy", 32'(busy), 32'h0);
    $display("scenario 4: frame 7e dropped, overrun=%0d", overrun);

    // 5: consumer takes frame 1 on the edge frame 2 completes
    do_reset();
    data_ready = 1'b0;
    two_frames_upto_24();
    data_ready = 1'b1;
    push_bit(1'b0);                  // edge 25
    check_val("t5_data", 32'(data_out), 32'h7E);
    check_val("t5_valid", 32'(data_valid), 32'h1);
    check_val("t5_ovr", 32'(overrun), 32'h0);
    data_ready = 1'b0;
    push_bit(1'b0);
    check_val("t5_hold_data", 32'(data_out), 32'h7E);
    check_val("t5_hold_valid", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    push_bit(1'b0);
    check_val("t5_taken", 32'(data_valid), 32'h0);
    $display("scenario 5: frame %0h received", 8'h7E);

    // 6: asynchronous reset in the middle of a frame
    do_reset();
    data_ready = 1'b0;
    push_nib(4'hA);
    push_nib(4'h3);
    push_nib(4'h5);
    push_nib(4'hA);                  // edges 13..16, frame 1 valid from 13
    push_nib(4'h7);                  // edges 17..20
    push_bit(1'b1);                  // edge 21: five payload bits in
    check_val("t6_busy_pre", 32'(busy), 32'h1);
    check_val("t6_valid_pre", 32'(data_valid), 32'h1);
    #3;
    reset = 1'b1;
    {q3, q2, q1, q0} = 4'b0000;
    #2;
    check_val("t6_rst_data", 32'(data_out), 32'h0);
    check_val("t6_rst_valid", 32'(data_valid), 32'h0);
    check_val("t6_rst_busy", 32'(busy), 32'h0);
    check_val("t6_rst_ovr", 32'(overrun), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    data_ready = 1'b1;
    push_nib(4'hA);
    push_nib(4'hC);
    push_nib(4'h3);
    push_bit(1'b0);
    check_val("t6_data", 32'(data_out), 32'hC3);
    check_val("t6_valid", 32'(data_valid), 32'h1);
    $display("scenario 6: frame %0h received after reset", 8'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
